jt5205_mc: RTL

- Multi-channel, time-multiplexed MSM5205-style 4-bit ADPCM decoder.
- One shared step-table/accumulator datapath serves CH channels. Each channel has its own sample-rate divider, nibble FIFO with valid/ready handshake, and 12-bit output.
- A wide unsaturated mix output is provided alongside the per-channel outputs.
- Sits between CPU/ROM sample fetchers and the sound mixer, replacing several single-channel decoders.

---
 rtl/jt5205_mc.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/jt5205_mc.sv
`default_nettype none
// ===========================================================================
// jt5205_mc : CH-lane time-multiplexed MSM5205-style 4-bit ADPCM decoder
// Revision  : 1.0
// ===========================================================================
module jt5205_mc #(
  parameter int CH    = 4,
  parameter int DEPTH = 2,
  parameter int MIXW  = 12 + $clog2(CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cen,
  input  logic [2*CH-1:0]        sel,
  input  logic [CH-1:0]          ch_rst,
  input  logic [4*CH-1:0]        din,
  input  logic [CH-1:0]          din_valid,
  output logic [CH-1:0]          din_ready,
  output logic [CH-1:0]          req,
  output logic [CH-1:0]          underrun,
  output logic [12*CH-1:0]       sound,
  output logic signed [MIXW-1:0] mix
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = (CH > 1) ? $clog2(CH) : 1;

  function automatic logic [10:0] step_lut(input logic [5:0] i);
    case (i)
      6'd0:  step_lut = 11'd16;   6'd1:  step_lut = 11'd17;   6'd2:  step_lut = 11'd19;
      6'd3:  step_lut = 11'd21;   6'd4:  step_lut = 11'd23;   6'd5:  step_lut = 11'd25;
      6'd6:  step_lut = 11'd28;   6'd7:  step_lut = 11'd31;   6'd8:  step_lut = 11'd34;
      6'd9:  step_lut = 11'd37;   6'd10: step_lut = 11'd41;   6'd11: step_lut = 11'd45;
      6'd12: step_lut = 11'd50;   6'd13: step_lut = 11'd55;   6'd14: step_lut = 11'd60;
      6'd15: step_lut = 11'd66;   6'd16: step_lut = 11'd73;   6'd17: step_lut = 11'd80;
      6'd18: step_lut = 11'd88;   6'd19: step_lut = 11'd97;   6'd20: step_lut = 11'd107;
      6'd21: step_lut = 11'd118;  6'd22: step_lut = 11'd130;  6'd23: step_lut = 11'd143;
      6'd24: step_lut = 11'd157;  6'd25: step_lut = 11'd173;  6'd26: step_lut = 11'd190;
      6'd27: step_lut = 11'd209;  6'd28: step_lut = 11'd230;  6'd29: step_lut = 11'd253;
      6'd30: step_lut = 11'd279;  6'd31: step_lut = 11'd307;  6'd32: step_lut = 11'd337;
      6'd33: step_lut = 11'd371;  6'd34: step_lut = 11'd408;  6'd35: step_lut = 11'd449;
      6'd36: step_lut = 11'd494;  6'd37: step_lut = 11'd544;  6'd38: step_lut = 11'd598;
      6'd39: step_lut = 11'd658;  6'd40: step_lut = 11'd724;  6'd41: step_lut = 11'd796;
      6'd42: step_lut = 11'd876;  6'd43: step_lut = 11'd963;  6'd44: step_lut = 11'd1060;
      6'd45: step_lut = 11'd1166; 6'd46: step_lut = 11'd1282; 6'd47: step_lut = 11'd1411;
      default: step_lut = 11'd1552;
    endcase
  endfunction

  function automatic logic [6:0] term_cnt(input logic [1:0] s);
    case (s)
      2'b00:   term_cnt = 7'd95;
      2'b01:   term_cnt = 7'd63;
      default: term_cnt = 7'd47;
    endcase
  endfunction

  function automatic logic signed [7:0] idx_delta(input logic [2:0] m);
    case (m)
      3'd4:    idx_delta = 8'sd2;
      3'd5:    idx_delta = 8'sd4;
      3'd6:    idx_delta = 8'sd6;
      3'd7:    idx_delta = 8'sd8;
      default: idx_delta = -8'sd1;
    endcase
  endfunction

  logic [6:0]         cnt [CH];
  logic [AW:0]        wp  [CH];
  logic [AW:0]        rp  [CH];
  logic [3:0]         mem [CH][DEPTH];
  logic signed [11:0] acc [CH];
  logic [5:0]         idx [CH];
  logic [CH-1:0]      pending, stop, empty, full, push, tick;
  logic [PW-1:0]      ptr, s1_ch;
  logic               s1_valid, s1_sign, svc, pop;
  logic [2:0]         s1_mag;
  logic [11:0]        s1_diff, step, diff;
  logic [3:0]         nib;
  logic signed [13:0] sum;
  logic signed [11:0] acc_nxt;
  logic signed [7:0]  idx_sum;
  logic [5:0]         idx_nxt;
  logic signed [MIXW-1:0] mix_sum;

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      stop[i]  = sel[2*i +: 2] == 2'b11;
      empty[i] = wp[i] == rp[i];
      full[i]  = (wp[i][AW] != rp[i][AW]) && (wp[i][AW-1:0] == rp[i][AW-1:0]);
      push[i]  = din_valid[i] && !full[i];
      tick[i]  = cen && !stop[i] && (cnt[i] >= term_cnt(sel[2*i +: 2]));
    end
  end

  assign din_ready = ~full;

  // Stage 1: service the lane under the round-robin pointer
  always_comb begin
    svc  = pending[ptr] && !ch_rst[ptr] && !stop[ptr];
    pop  = svc && !empty[ptr];
    nib  = mem[ptr][rp[ptr][AW-1:0]];
    step = {1'b0, step_lut(idx[ptr])};
    diff = (step >> 3) + (nib[0] ? (step >> 2) : 12'd0)
         + (nib[1] ? (step >> 1) : 12'd0) + (nib[2] ? step : 12'd0);
  end

  // Stage 2: saturating accumulate and clamped index adaptation
  always_comb begin
    sum = s1_sign ? 14'(acc[s1_ch]) - $signed({2'b00, s1_diff})
                  : 14'(acc[s1_ch]) + $signed({2'b00, s1_diff});
    if (sum > 14'sd2047)       acc_nxt = 12'sd2047;
    else if (sum < -14'sd2048) acc_nxt = -12'sd2048;
    else                       acc_nxt = sum[11:0];
    idx_sum = $signed({2'b00, idx[s1_ch]}) + idx_delta(s1_mag);
    if (idx_sum < 8'sd0)       idx_nxt = 6'd0;
    else if (idx_sum > 8'sd48) idx_nxt = 6'd48;
    else                       idx_nxt = idx_sum[5:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        cnt[i] <= '0; wp[i] <= '0; rp[i] <= '0; acc[i] <= '0; idx[i] <= '0;
      end
      pending  <= '0;
      req      <= '0;
      underrun <= '0;
      ptr      <= '0;
      s1_valid <= 1'b0;
      s1_ch    <= '0;
      s1_sign  <= 1'b0;
      s1_mag   <= '0;
      s1_diff  <= '0;
    end else begin
      req      <= tick;
      underrun <= '0;
      ptr      <= (ptr == PW'(CH-1)) ? '0 : ptr + 1'b1;
      s1_valid <= pop;
      s1_ch    <= ptr;
      s1_sign  <= nib[3];
      s1_mag   <= nib[2:0];
      s1_diff  <= diff;
      if (svc) pending[ptr] <= 1'b0;
      if (svc && empty[ptr]) underrun[ptr] <= 1'b1;
      if (pop) rp[ptr] <= rp[ptr] + 1'b1;
      if (s1_valid && !ch_rst[s1_ch]) begin
        acc[s1_ch] <= acc_nxt;
        idx[s1_ch] <= idx_nxt;
      end
      for (int i = 0; i < CH; i++) begin
        if (push[i]) wp[i] <= wp[i] + 1'b1;
        if (stop[i]) begin
          cnt[i]     <= '0;
          pending[i] <= 1'b0;
        end else if (tick[i]) begin
          cnt[i]     <= '0;
          pending[i] <= 1'b1;
        end else if (cen) begin
          cnt[i] <= cnt[i] + 7'd1;
        end
        // Soft reset is applied last so it overrides every other update on the lane
        if (ch_rst[i]) begin
          cnt[i] <= '0; wp[i] <= '0; rp[i] <= '0; acc[i] <= '0; idx[i] <= '0;
          pending[i] <= 1'b0; req[i] <= 1'b0; underrun[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < CH; i++)
      if (push[i]) mem[i][wp[i][AW-1:0]] <= din[4*i +: 4];
  end

  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < CH; i++) mix_sum = mix_sum + MIXW'(acc[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mix <= '0;
    else        mix <= mix_sum;
  end

  for (genvar g = 0; g < CH; g++) begin : g_lane
    assign sound[12*g +: 12] = acc[g];
  end

endmodule
`default_nettype wire
